fpu_sqrt_issue: RTL and testbench

- Valid/ready front end and result collector wrapped around the fixed-latency, non-stallable sqrt pipeline.
- Accepts tagged sqrt requests from the FPU dispatch and feeds operands to an internal sqrt instance.
- Tracks in-flight ops with a valid/tag shift register and captures results into a small output FIFO.
- Credit accounting guarantees the FIFO never overflows, because the pipeline cannot be stalled.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_sqrt_issue_if.sv | 23 ++
 rtl/fpu_result_fifo.sv | 38 +++
 rtl/fpu_sqrt.sv | 53 +++++
 rtl/fpu_sqrt_issue.sv | 109 ++++++++++
 tb/tb_fpu_sqrt_issue.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants, result flag indices and the sqrt special-operand class.
package fpu_pkg;

  localparam int TAG_W = 6;

  localparam logic [31:0] FP_QNAN  = 32'h7fc00000;
  localparam logic [31:0] FP_PINF  = 32'h7f800000;
  localparam logic [31:0] FP_NZERO = 32'h80000000;

  localparam int FLG_INVALID = 1;
  localparam int FLG_INEXACT = 0;

  typedef enum logic [1:0] {
    CLS_NORM    = 2'd0,
    CLS_INVALID = 2'd1,
    CLS_PINF    = 2'd2,
    CLS_NZERO   = 2'd3
  } sqrt_cls_e;

  // NaN of either sign and any negative nonzero value (incl. -inf) are invalid.
  function automatic sqrt_cls_e sqrt_classify(input logic [31:0] a);
    sqrt_cls_e c;
    c = CLS_NORM;
    if ((a[30:23] == 8'hff) && (a[22:0] != 23'h0)) c = CLS_INVALID;
    else if (a[31] && (a[30:0] != 31'h0))          c = CLS_INVALID;
    else if (a == FP_PINF)                         c = CLS_PINF;
    else if (a == FP_NZERO)                        c = CLS_NZERO;
    return c;
  endfunction

endpackage

// File: rtl/fpu_sqrt_issue_if.sv
// Request/result handshake bundle between FPU dispatch, the sqrt issue block and its consumer.
interface fpu_sqrt_issue_if #(parameter int TAG_W = fpu_pkg::TAG_W);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_flags;
  logic             busy;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_flags, busy
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_flags, busy
  );
endinterface

// File: rtl/fpu_result_fifo.sv
// Generic fall-through result FIFO; DEPTH must be a power of two (wrap-bit pointers).
module fpu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head is forced to zero when empty so stale entries never leak onto the bus.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/fpu_sqrt.sv
// Fixed-latency, non-stallable single-precision sqrt: NSTAGE+1 edges from x to y.
module fpu_sqrt #(
  parameter int NSTAGE = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic [31:0]              x_q;
  logic [NSTAGE-1:0][31:0]  r;

  // Denormals flush to signed zero; inf/NaN keep their payload with sign cleared.
  function automatic logic [31:0] fsqrt(input logic [31:0] a);
    logic [7:0]  e, ex;
    logic [47:0] rad;
    logic [23:0] root;
    logic [26:0] rem, trial;
    logic [31:0] res;
    e    = a[30:23];
    rad  = e[0] ? {1'b0, 1'b1, a[22:0], 23'b0} : {1'b1, a[22:0], 24'b0};
    root = '0;
    rem  = '0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[24:0], rad[2*i+1 -: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
    ex  = 8'(({1'b0, e} + 9'd127) >> 1);
    res = {1'b0, ex, root[22:0]};
    if (e == 8'h00)      res = {a[31], 31'h0};
    else if (e == 8'hff) res = {1'b0, a[30:0]};
    return res;
  endfunction

  // The root resolves in the first stage; later stages are retiming slack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q <= '0;
      r   <= '0;
    end else begin
      x_q <= x;
      r   <= {r[NSTAGE-2:0], fsqrt(x_q)};
    end
  end

  assign y = r[NSTAGE-1];
endmodule

// File: rtl/fpu_sqrt_issue.sv
// Valid/ready issue front end and result collector around the sqrt pipeline.
// Optional macro SQRT_EXC_EN: special-operand class rides with the tag and overrides y/flags.
module fpu_sqrt_issue
  import fpu_pkg::*;
#(
  parameter int LAT    = 6,
  parameter int NSTAGE = 5,
  parameter int TAG_W  = fpu_pkg::TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  fpu_sqrt_issue_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = 32 + TAG_W + 2;
  localparam logic [CW-1:0] CR_ONE = 1;

  logic [CW-1:0]             credit;
  logic                      accept, pop, push;
  logic [31:0]               x, y;
  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][TAG_W-1:0] tag_pipe;
  logic [31:0]               cap_y;
  logic [1:0]                cap_flags;
  logic [FW-1:0]             head;
  logic                      empty, full;

  // Credit covers in-flight plus queued ops, so the FIFO always has room for
  // whatever emerges from the unstallable pipeline.
  assign bus.in_ready = rstn && (credit < CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign push         = vld_pipe[LAT-1];
  assign x            = accept ? bus.in_x : 32'h0;
  assign bus.busy     = (credit != '0);

  fpu_sqrt #(.NSTAGE(NSTAGE)) u_sqrt (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y)
  );

  // LAT must match the sqrt latency (NSTAGE+1) so entry LAT-1 lines up with y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], accept};
      tag_pipe <= {tag_pipe[LAT-2:0], bus.in_tag};
    end
  end

`ifdef SQRT_EXC_EN
  logic [LAT-1:0][1:0] cls_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cls_pipe <= '0;
    else       cls_pipe <= {cls_pipe[LAT-2:0], 2'(sqrt_classify(bus.in_x))};
  end

  always_comb begin
    cap_y     = y;
    cap_flags = 2'b00;
    case (sqrt_cls_e'(cls_pipe[LAT-1]))
      CLS_INVALID: begin
        cap_y                  = FP_QNAN;
        cap_flags[FLG_INVALID] = 1'b1;
      end
      CLS_PINF:  cap_y = FP_PINF;
      CLS_NZERO: cap_y = FP_NZERO;
      default:   cap_y = y;
    endcase
    cap_flags[FLG_INEXACT] = 1'b0;
  end
`else
  assign cap_y     = y;
  assign cap_flags = 2'b00;
`endif

  fpu_result_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata ({cap_y, tag_pipe[LAT-1], cap_flags}),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign bus.out_valid = !empty;
  assign {bus.out_y, bus.out_tag, bus.out_flags} = head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) credit <= '0;
    else begin
      case ({accept, pop})
        2'b10:   credit <= credit + CR_ONE;
        2'b01:   credit <= credit - CR_ONE;
        default: credit <= credit;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
endmodule

// File: tb/tb_fpu_sqrt_issue.sv
// Directed table plus hand-written corner sequences for fpu_sqrt_issue.
module tb_fpu_sqrt_issue;
  localparam int LAT = 6, DEPTH = 4, TW = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fpu_sqrt_issue_if #(.TAG_W(TW)) bus ();

  fpu_sqrt_issue #(.LAT(LAT), .NSTAGE(5), .TAG_W(TW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0]   x;
    logic [TW-1:0] tag;
    logic [31:0]   y;
    logic [1:0]    flags;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] x, input logic [TW-1:0] tag,
                     input logic [31:0] y, input logic [1:0] flags);
    vec_t v;
    v.x = x; v.tag = tag; v.y = y; v.flags = flags;
    tbl.push_back(v);
  endtask

  initial begin
    int cyc, got, first, acc, pops;
    logic [31:0] sx[3], sy[3], rx[4], ry[4];
    logic [TW-1:0] tagc, idx_tag;
    logic [TW-1:0] exp_tags[4];
    logic [37:0] q[$];
    logic [37:0] e;
    int idx;

    add(32'h40800000, 6'd5,  32'h40000000, 2'b00);
    add(32'h3f800000, 6'd1,  32'h3f800000, 2'b00);
    add(32'h41100000, 6'd2,  32'h40400000, 2'b00);
    add(32'h00000000, 6'd3,  32'h00000000, 2'b00);
    add(32'h41800000, 6'd63, 32'h40800000, 2'b00);
    add(32'h3e800000, 6'd10, 32'h3f000000, 2'b00);
    add(32'h40100000, 6'd11, 32'h3fc00000, 2'b00);
    add(32'h7f800000, 6'd12, 32'h7f800000, 2'b00);
`ifdef SQRT_EXC_EN
    add(32'hc0800000, 6'd13, 32'h7fc00000, 2'b10);
    add(32'h80000000, 6'd14, 32'h80000000, 2'b00);
    add(32'h7fc00001, 6'd15, 32'h7fc00000, 2'b10);
`else
    add(32'hc0800000, 6'd13, 32'h40000000, 2'b00);
`endif

    bus.in_valid = 0; bus.in_x = 0; bus.in_tag = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    rstn = 1;

    // Single ops from the table
    foreach (tbl[i]) begin
      @(negedge clk);
      chk("tbl_in_ready", bus.in_ready, 1);
      bus.in_valid = 1; bus.in_x = tbl[i].x; bus.in_tag = tbl[i].tag; bus.out_ready = 1;
      @(negedge clk);
      bus.in_valid = 0; bus.in_x = 0;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      chk("tbl_latency", cyc, LAT);
      chk("tbl_y", bus.out_y, tbl[i].y);
      chk("tbl_tag", bus.out_tag, tbl[i].tag);
      chk("tbl_flags", bus.out_flags, tbl[i].flags);
      chk("tbl_busy_hi", bus.busy, 1);
      @(negedge clk);
      chk("tbl_busy_lo", bus.busy, 0);
      chk("tbl_valid_lo", bus.out_valid, 0);
    end

    // Back-to-back stream
    sx[0] = 32'h3f800000; sx[1] = 32'h41100000; sx[2] = 32'h00000000;
    sy[0] = 32'h3f800000; sy[1] = 32'h40400000; sy[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1; bus.in_x = sx[i]; bus.in_tag = 6'(40 + i);
    end
    @(negedge clk);
    bus.in_valid = 0;
    got = 0; first = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        if (got == 0) first = c;
        if (got < 3) begin
          chk("stream_y", bus.out_y, sy[got]);
          chk("stream_tag", bus.out_tag, 40 + got);
          chk("stream_cycle", c, first + got);
        end
        got++;
      end
      @(negedge clk);
    end
    chk("stream_count", got, 3);

    // Backpressure: only DEPTH accepted while the consumer stalls
    bus.out_ready = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_x = 32'h40800000; bus.in_tag = 6'(20 + i);
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 0;
    chk("bp_accepted", acc, DEPTH);
    repeat (8) @(negedge clk);
    chk("bp_in_ready_lo", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1; pops = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        if (pops == 0) chk("bp_ready_same_cycle", bus.in_ready, 0);
        chk("bp_tag", bus.out_tag, 20 + pops);
        chk("bp_y", bus.out_y, 32'h40000000);
        pops++;
      end
      @(negedge clk);
    end
    chk("bp_pops", pops, DEPTH);
    chk("bp_in_ready_hi", bus.in_ready, 1);
    chk("bp_busy_lo", bus.busy, 0);

    // Simultaneous accept and pop at credit 3
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_x = 32'h3f800000; bus.in_tag = 6'(30 + i);
      @(negedge clk);
    end
    bus.in_valid = 0;
    repeat (8) @(negedge clk);
    chk("c3_credit", dut.credit, 3);
    bus.in_valid = 1; bus.in_tag = 6'd33; bus.out_ready = 1;
    chk("c3_head_tag", bus.out_tag, 30);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0;
    chk("c3_credit_same", dut.credit, 3);
    chk("c3_in_ready", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_tag = 6'd34;
    @(negedge clk);
    bus.in_valid = 0;
    chk("c3_full_ready_lo", bus.in_ready, 0);
    exp_tags[0] = 6'd31; exp_tags[1] = 6'd32; exp_tags[2] = 6'd33; exp_tags[3] = 6'd34;
    bus.out_ready = 1; pops = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        if (pops < 4) chk("c3_drain_tag", bus.out_tag, exp_tags[pops]);
        pops++;
      end
      @(negedge clk);
    end
    chk("c3_drain_count", pops, 4);

    // Reset two cycles after an accept
    bus.in_valid = 1; bus.in_x = 32'h40800000; bus.in_tag = 6'd50;
    @(negedge clk);
    bus.in_valid = 0;
    @(negedge clk);
    rstn = 0;
    #1;
    chk("rmid_in_ready", bus.in_ready, 0);
    chk("rmid_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rmid_no_stale", bus.out_valid, 0);
    end
    chk("rmid_in_ready_hi", bus.in_ready, 1);

    // Random valid/ready against a scoreboard of exact squares
    rx[0] = 32'h40800000; ry[0] = 32'h40000000;
    rx[1] = 32'h41100000; ry[1] = 32'h40400000;
    rx[2] = 32'h3e800000; ry[2] = 32'h3f000000;
    rx[3] = 32'h41800000; ry[3] = 32'h40800000;
    tagc = 0;
    for (int c = 0; c < 1040; c++) begin
      idx = $urandom_range(0, 3);
      bus.in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_x      = rx[idx];
      bus.in_tag    = tagc;
      bus.out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_pop", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_y", bus.out_y, e[37:6]);
          chk("rnd_tag", bus.out_tag, e[5:0]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        idx_tag = tagc;
        q.push_back({ry[idx], idx_tag});
        tagc++;
      end
      @(negedge clk);
    end
    chk("rnd_sb_empty", q.size(), 0);
    chk("rnd_busy_lo", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
